// File: rtl/uart_reg_responder.sv
// Host-side command responder: parses 'W' addr data / 'R' addr byte streams from
// the UART receiver into a 16 x 8-bit register file, one response byte per command.
module uart_reg_responder #(
  parameter int clk_freq      = 1000000,
  parameter int baud_rate     = 9600,
  parameter int timeout_bytes = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic [7:0] tx_data,
  output logic       tx_send,
  input  logic       tx_busy,
  input  logic [7:0] status_in,
  output logic [7:0] ctrl_out,
  output logic       cmd_error
);

  localparam int TIMEOUT = timeout_bytes * 10 * (clk_freq / baud_rate);
  localparam int CW      = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  localparam logic [7:0] CH_W    = 8'h57;
  localparam logic [7:0] CH_R    = 8'h52;
  localparam logic [7:0] CH_ACK  = 8'h4B;
  localparam logic [7:0] CH_NAK  = 8'h3F;
  localparam logic [3:0] STAT_AD = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_ADDR,
    S_GET_DATA,
    S_EXEC,
    S_SEND,
    S_WAIT_ACK
  } state_t;

  state_t           state_q, state_d;
  logic             is_wr_q, is_wr_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       data_q, data_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_send_q, tx_send_d;
  logic             cmd_error_q, cmd_error_d;
  logic [15:0][7:0] regs_q;
  logic             reg_we;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      is_wr_q     <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      cnt_q       <= '0;
      tx_data_q   <= '0;
      tx_send_q   <= 1'b0;
      cmd_error_q <= 1'b0;
      regs_q      <= '0;
    end else begin
      state_q     <= state_d;
      is_wr_q     <= is_wr_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      tx_data_q   <= tx_data_d;
      tx_send_q   <= tx_send_d;
      cmd_error_q <= cmd_error_d;
      if (reg_we) regs_q[addr_q[3:0]] <= data_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    is_wr_d     = is_wr_q;
    addr_d      = addr_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    tx_data_d   = tx_data_q;
    tx_send_d   = 1'b0;
    cmd_error_d = 1'b0;
    reg_we      = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (rx_ready) begin
          if (rx_data == CH_W || rx_data == CH_R) begin
            is_wr_d = (rx_data == CH_W);
            state_d = S_GET_ADDR;
          end else begin
            tx_data_d   = CH_NAK;
            cmd_error_d = 1'b1;
            state_d     = S_SEND;
          end
        end
      end

      // An arriving byte beats a simultaneous timeout expiry.
      S_GET_ADDR: begin
        if (rx_ready) begin
          addr_d  = rx_data;
          cnt_d   = '0;
          state_d = is_wr_q ? S_GET_DATA : S_EXEC;
        end else if (cnt_q == TO_LAST) begin
          cnt_d       = '0;
          cmd_error_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_GET_DATA: begin
        if (rx_ready) begin
          data_d  = rx_data;
          cnt_d   = '0;
          state_d = S_EXEC;
        end else if (cnt_q == TO_LAST) begin
          cnt_d       = '0;
          cmd_error_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      // Address 0x0F is the status port: writes are acknowledged but discarded.
      S_EXEC: begin
        if (addr_q[7:4] != 4'h0) begin
          tx_data_d   = CH_NAK;
          cmd_error_d = 1'b1;
        end else if (is_wr_q) begin
          reg_we    = (addr_q[3:0] != STAT_AD);
          tx_data_d = CH_ACK;
        end else if (addr_q[3:0] == STAT_AD) begin
          tx_data_d = status_in;
        end else begin
          tx_data_d = regs_q[addr_q[3:0]];
        end
        if (rx_ready) cmd_error_d = 1'b1;
        state_d = S_SEND;
      end

      S_SEND: begin
        if (rx_ready) cmd_error_d = 1'b1;
        if (!tx_busy) begin
          tx_send_d = 1'b1;
          state_d   = S_WAIT_ACK;
        end
      end

      S_WAIT_ACK: begin
        if (rx_ready) cmd_error_d = 1'b1;
        if (tx_busy) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign tx_data   = tx_data_q;
  assign tx_send   = tx_send_q;
  assign cmd_error = cmd_error_q;
  assign ctrl_out  = regs_q[0];

endmodule

// File: tb/tb_uart_reg_responder.sv
// Randomized bench for uart_reg_responder against a command-level register model.
module tb_uart_reg_responder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_ready = 1'b0;
  logic [7:0] tx_data;
  logic       tx_send;
  logic       tx_busy;
  logic [7:0] status_in = 8'h00;
  logic [7:0] ctrl_out;
  logic       cmd_error;

  logic       auto_tx = 1'b1;
  logic       man_busy = 1'b0;
  int         bcnt = 0;
  logic [7:0] rsp_q[$];
  int         err_cnt = 0;
  int         n_chk = 0;
  int         n_err = 0;
  logic [7:0] mem [16];

  uart_reg_responder dut (
    .clk      (clk),
    .reset    (reset),
    .rx_data  (rx_data),
    .rx_ready (rx_ready),
    .tx_data  (tx_data),
    .tx_send  (tx_send),
    .tx_busy  (tx_busy),
    .status_in(status_in),
    .ctrl_out (ctrl_out),
    .cmd_error(cmd_error)
  );

  always #5 clk = ~clk;

  // Simple transmitter: busy for a few cycles after each send request.
  assign tx_busy = auto_tx ? (bcnt != 0) : man_busy;
  always @(posedge clk) begin
    if (tx_send) bcnt <= 4;
    else if (bcnt != 0) bcnt <= bcnt - 1;
  end

  always @(negedge clk) begin
    if (tx_send) rsp_q.push_back(tx_data);
    if (cmd_error) err_cnt <= err_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
  endtask

  // Sends one command, derives the expected reply from the command rules,
  // then checks reply, error pulses and the control register.
  task automatic run_cmd(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input int gap);
    logic [7:0] exp;
    int         eerr;
    int         nb;
    int         e0;
    rsp_q.delete();
    e0 = err_cnt;
    eerr = 0;
    if (b0 != 8'h57 && b0 != 8'h52) begin
      nb = 1; exp = 8'h3F; eerr = 1;
    end else begin
      nb = (b0 == 8'h57) ? 3 : 2;
      if (b1 > 8'h0F) begin
        exp = 8'h3F; eerr = 1;
      end else if (b0 == 8'h52) begin
        exp = (b1 == 8'h0F) ? status_in : mem[b1];
      end else begin
        exp = 8'h4B;
        if (b1 != 8'h0F) mem[b1] = b2;
      end
    end
    send_byte(b0);
    if (nb > 1) begin repeat (gap) @(negedge clk); send_byte(b1); end
    if (nb > 2) begin repeat (gap) @(negedge clk); send_byte(b2); end
    repeat (12) @(negedge clk);
    chk({tag, "_nrsp"}, rsp_q.size(), 1);
    chk({tag, "_rsp"}, rsp_q.size() > 0 ? rsp_q[0] : 8'hxx, exp);
    chk({tag, "_err"}, err_cnt - e0, eerr);
    chk({tag, "_ctrl"}, ctrl_out, mem[0]);
  endtask

  initial begin
    int         e0;
    logic [7:0] b0, a, d;
    model_reset();

    repeat (3) @(negedge clk);
    chk("rst_tx_send", tx_send, 0);
    chk("rst_cmd_error", cmd_error, 0);
    chk("rst_ctrl", ctrl_out, 8'h00);
    chk("rst_tx_data", tx_data, 8'h00);
    reset = 1'b0;

    // First write with cycle-accurate latency checks
    rsp_q.delete();
    e0 = err_cnt;
    send_byte(8'h57);
    send_byte(8'h00);
    send_byte(8'hA5);
    chk("lat_ctrl_E", ctrl_out, 8'h00);
    chk("lat_send_E", tx_send, 0);
    @(negedge clk);
    chk("lat_ctrl_E1", ctrl_out, 8'hA5);
    chk("lat_send_E1", tx_send, 0);
    @(negedge clk);
    chk("lat_send_E2", tx_send, 1);
    chk("lat_data_E2", tx_data, 8'h4B);
    mem[0] = 8'hA5;
    repeat (12) @(negedge clk);
    chk("lat_nrsp", rsp_q.size(), 1);
    chk("lat_err", err_cnt - e0, 0);
    run_cmd("rd0", 8'h52, 8'h00, 8'h00, 0);

    status_in = 8'h3C;
    run_cmd("stat_rd", 8'h52, 8'h0F, 8'h00, 0);
    run_cmd("stat_wr", 8'h57, 8'h0F, 8'hFF, 0);
    run_cmd("stat_rd2", 8'h52, 8'h0F, 8'h00, 0);

    run_cmd("bad_cmd", 8'h41, 8'h00, 8'h00, 0);
    run_cmd("bad_rd", 8'h52, 8'h10, 8'h00, 0);
    run_cmd("bad_wr", 8'h57, 8'h25, 8'h77, 0);

    // Inter-byte timeout
    rsp_q.delete();
    e0 = err_cnt;
    send_byte(8'h57);
    send_byte(8'h03);
    repeat (4100) @(negedge clk);
    chk("to_early", err_cnt - e0, 0);
    for (int i = 0; i < 200 && err_cnt == e0; i++) @(negedge clk);
    chk("to_err", err_cnt - e0, 1);
    repeat (10) @(negedge clk);
    chk("to_norsp", rsp_q.size(), 0);
    run_cmd("to_rd3", 8'h52, 8'h03, 8'h00, 0);

    // Total gap exceeds the timeout, but each accepted byte restarts the count
    run_cmd("gap_wr", 8'h57, 8'h05, 8'h9A, 3000);
    run_cmd("gap_rd", 8'h52, 8'h05, 8'h00, 0);

    // Busy handshake
    auto_tx = 1'b0;
    man_busy = 1'b1;
    rsp_q.delete();
    e0 = err_cnt;
    send_byte(8'h52);
    send_byte(8'h00);
    repeat (10) @(negedge clk);
    chk("bsy_hold", rsp_q.size(), 0);
    man_busy = 1'b0;
    for (int i = 0; i < 5 && rsp_q.size() == 0; i++) @(negedge clk);
    chk("bsy_rsp", rsp_q.size() > 0 ? rsp_q[0] : 8'hxx, mem[0]);
    send_byte(8'h57);
    repeat (5) @(negedge clk);
    chk("bsy_drop_err", err_cnt - e0, 1);
    chk("bsy_one_pulse", rsp_q.size(), 1);
    man_busy = 1'b1;
    repeat (2) @(negedge clk);
    man_busy = 1'b0;
    auto_tx = 1'b1;
    repeat (5) @(negedge clk);
    run_cmd("bsy_after", 8'h52, 8'h00, 8'h00, 0);

    // Randomized command mix
    for (int n = 0; n < 40; n++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind < 5) b0 = 8'h57;
      else if (kind < 9) b0 = 8'h52;
      else begin
        b0 = 8'($urandom);
        while (b0 == 8'h57 || b0 == 8'h52) b0 = 8'($urandom);
      end
      a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(16, 255)) : 8'($urandom_range(0, 15));
      d = 8'($urandom);
      status_in = 8'($urandom);
      run_cmd($sformatf("rnd%0d", n), b0, a, d, 0);
    end

    // Reset between address and data of a write
    run_cmd("pre_rst", 8'h57, 8'h00, 8'hC3, 0);
    rsp_q.delete();
    send_byte(8'h57);
    send_byte(8'h00);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_ctrl", ctrl_out, 8'h00);
    chk("mid_rst_send", tx_send, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("mid_rst_norsp", rsp_q.size(), 0);
    run_cmd("post_rst_wr", 8'h57, 8'h00, 8'h11, 0);
    run_cmd("post_rst_rd", 8'h52, 8'h00, 8'h00, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
